// File: rtl/pipe_add.sv
// Pipelined WIDTH-bit add/subtract with carry-in/borrow-in, carry-out and signed overflow.
// Latency: result valid STAGES edges after the accept edge (input register + STAGES chunk stages).
// Backpressure: global advance enable; out_valid && !out_ready freezes every stage and drops in_ready.
module pipe_add #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  // Level 0 is the operand register; level k (1..STAGES) holds the result
  // after chunk k-1 has been summed. Operands ride along (skew) until their
  // chunk is consumed, and finished low chunks ride along (de-skew) in r_s.
  logic             r_vld [STAGES+1];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_s   [STAGES+1];
  logic             r_c   [STAGES+1];
  logic             r_ovf;

  logic             w_en;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_s_n [STAGES+1];
  logic             w_c_n [STAGES+1];
  logic             w_ovf_n;

  // A stalled output blocks the whole pipe; no bubble collapsing.
  assign w_en      = !r_vld[STAGES] || out_ready;
  assign in_ready  = w_en && !sys_rst;
  assign w_b_eff   = sub ? ~b : b;

  assign out_valid = r_vld[STAGES];
  assign sum       = r_s[STAGES];
  assign cout      = r_c[STAGES];
  assign ovf       = r_ovf;

  // Per-stage chunk adder fed by the previous level's registered carry.
  always_comb begin
    logic [CHUNK:0] w_t;
    w_t = '0;
    for (int k = 0; k <= STAGES; k++) begin
      w_s_n[k] = '0;
      w_c_n[k] = 1'b0;
    end
    for (int k = 1; k <= STAGES; k++) begin
      w_t = {1'b0, r_a[k-1][(k-1)*CHUNK +: CHUNK]}
          + {1'b0, r_b[k-1][(k-1)*CHUNK +: CHUNK]}
          + {{CHUNK{1'b0}}, r_c[k-1]};
      w_s_n[k]                        = r_s[k-1];
      w_s_n[k][(k-1)*CHUNK +: CHUNK]  = w_t[CHUNK-1:0];
      w_c_n[k]                        = w_t[CHUNK];
    end
    // Same-sign operands producing an opposite-sign result is exactly
    // carry-into-MSB XOR carry-out-of-MSB.
    w_ovf_n = (r_a[STAGES-1][WIDTH-1] == r_b[STAGES-1][WIDTH-1])
           && (w_s_n[STAGES][WIDTH-1] != r_a[STAGES-1][WIDTH-1]);
  end

  // Pipeline registers: cleared by reset, advanced only on the global enable.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int k = 0; k <= STAGES; k++) begin
        r_vld[k] <= 1'b0;
        r_s[k]   <= '0;
        r_c[k]   <= 1'b0;
      end
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
      r_ovf <= 1'b0;
    end else if (w_en) begin
      r_vld[0] <= in_valid;
      r_a[0]   <= a;
      r_b[0]   <= w_b_eff;
      r_s[0]   <= '0;
      r_c[0]   <= cin ^ sub;
      for (int k = 1; k <= STAGES; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_s[k]   <= w_s_n[k];
        r_c[k]   <= w_c_n[k];
      end
      for (int k = 1; k < STAGES; k++) begin
        r_a[k] <= r_a[k-1];
        r_b[k] <= r_b[k-1];
      end
      r_ovf <= w_ovf_n;
    end
  end

endmodule

// File: tb/tb_pipe_add.sv
// Bench for pipe_add: vector table, random back-pressured stream vs. arithmetic model.
// Latency: checks STAGES-edge latency on 16/4, 8/1 and 8/8 instances.
// Backpressure: drops out_ready mid-stream and checks freeze, order and count.
module tb_pipe_add;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        iv16, ir16, ov16, or16, cin16, sub16, co16, of16;
  logic [15:0] a16, b16, s16;
  logic        iv81, ir81, ov81, or81, cin81, sub81, co81, of81;
  logic [7:0]  a81, b81, s81;
  logic        iv88, ir88, ov88, or88, cin88, sub88, co88, of88;
  logic [7:0]  a88, b88, s88;

  pipe_add #(.WIDTH(16), .STAGES(4)) u16 (
    .sys_clk(clk), .sys_rst(rst), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .ovf(of16));

  pipe_add #(.WIDTH(8), .STAGES(1)) u81 (
    .sys_clk(clk), .sys_rst(rst), .in_valid(iv81), .in_ready(ir81),
    .a(a81), .b(b81), .cin(cin81), .sub(sub81),
    .out_valid(ov81), .out_ready(or81), .sum(s81), .cout(co81), .ovf(of81));

  pipe_add #(.WIDTH(8), .STAGES(8)) u88 (
    .sys_clk(clk), .sys_rst(rst), .in_valid(iv88), .in_ready(ir88),
    .a(a88), .b(b88), .cin(cin88), .sub(sub88),
    .out_valid(ov88), .out_ready(or88), .sum(s88), .cout(co88), .ovf(of88));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        of;
  } vec_t;

  typedef struct {
    longint s;
    bit     co;
    bit     of;
  } res_t;

  int   total = 0;
  int   bad   = 0;
  res_t q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Reference: plain unsigned/signed integer arithmetic on w-bit operands.
  function automatic res_t model(input int w, input longint ua, input longint ub,
                                 input bit ci, input bit sb);
    longint m, sa, sbv, u, s;
    res_t   r;
    m   = longint'(1) << w;
    sa  = (ua >= m / 2) ? ua - m : ua;
    sbv = (ub >= m / 2) ? ub - m : ub;
    if (!sb) begin
      u    = ua + ub + longint'(ci);
      s    = sa + sbv + longint'(ci);
      r.co = (u >= m);
    end else begin
      u    = ua - ub - longint'(ci);
      s    = sa - sbv - longint'(ci);
      r.co = (ua >= ub + longint'(ci));
    end
    r.s  = u & (m - 1);
    r.of = (s >= m / 2) || (s < -(m / 2));
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run16(input vec_t v, input string nm);
    int e;
    a16 = v.a; b16 = v.b; cin16 = v.cin; sub16 = v.sub; iv16 = 1'b1;
    #1;
    chk({nm, " in_ready"}, ir16, 1);
    tick;
    iv16 = 1'b0;
    e = 0;
    while (!ov16 && e < 20) begin
      tick;
      e++;
    end
    chk({nm, " latency"}, e, 4);
    chk({nm, " sum"}, s16, v.s);
    chk({nm, " cout"}, co16, v.co);
    chk({nm, " ovf"}, of16, v.of);
    tick;
    chk({nm, " drained"}, ov16, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[9];
    res_t        r;
    int          sent, got, sp, e;
    logic [15:0] hs;
    logic        hc, ho, held;

    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[2] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    tbl[5] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
    tbl[6] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[8] = '{16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0};

    // Reset held for two edges with live random inputs.
    rst = 1'b1;
    iv16 = 1'b1; or16 = 1'b1;
    a16 = 16'($urandom); b16 = 16'($urandom);
    cin16 = 1'($urandom); sub16 = 1'($urandom);
    iv81 = 1'b0; or81 = 1'b1; a81 = '0; b81 = '0; cin81 = 1'b0; sub81 = 1'b0;
    iv88 = 1'b0; or88 = 1'b1; a88 = '0; b88 = '0; cin88 = 1'b0; sub88 = 1'b0;
    tick;
    tick;
    chk("reset out_valid", ov16, 0);
    chk("reset sum", s16, 0);
    chk("reset cout", co16, 0);
    chk("reset ovf", of16, 0);
    chk("reset in_ready", ir16, 0);
    chk("reset out_valid 8x1", ov81, 0);
    chk("reset out_valid 8x8", ov88, 0);
    rst = 1'b0;
    iv16 = 1'b0;
    #1;
    chk("post-reset in_ready", ir16, 1);
    chk("post-reset out_valid", ov16, 0);

    // Directed vector table, one operation at a time.
    for (int i = 0; i < 9; i++) begin
      run16(tbl[i], $sformatf("vec%0d", i));
    end

    // Random back-to-back stream with a 3-cycle output stall.
    sent = 0; got = 0; held = 1'b0; hs = '0; hc = 1'b0; ho = 1'b0;
    for (int k = 0; k < 60 && got < 8; k++) begin
      tick;
      or16  = !(k >= 6 && k < 9);
      iv16  = (sent < 8);
      a16   = 16'($urandom); b16 = 16'($urandom);
      cin16 = 1'($urandom); sub16 = 1'($urandom);
      #1;
      if (!or16) begin
        chk("stall in_ready", ir16, 0);
        if (!held) begin
          chk("stall out_valid", ov16, 1);
          hs = s16; hc = co16; ho = of16; held = 1'b1;
        end else begin
          chk("stall sum frozen", s16, hs);
          chk("stall cout frozen", co16, hc);
          chk("stall ovf frozen", of16, ho);
        end
      end else if (ov16) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stream extra result: got %0h, want none", s16);
        end else begin
          r = q.pop_front();
          chk($sformatf("stream%0d sum", got), s16, r.s);
          chk($sformatf("stream%0d cout", got), co16, r.co);
          chk($sformatf("stream%0d ovf", got), of16, r.of);
          got++;
        end
      end
      if (iv16 && ir16) begin
        q.push_back(model(16, longint'(a16), longint'(b16), cin16, sub16));
        sent++;
      end
    end
    tick;
    iv16 = 1'b0; or16 = 1'b1;
    chk("stream count", got, 8);
    chk("stream leftover", q.size(), 0);
    tick;
    tick;

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom);
      cin16 = 1'($urandom); sub16 = 1'($urandom);
      iv16 = 1'b1;
      tick;
    end
    iv16 = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid-reset out_valid", ov16, 0);
    sp = 0;
    repeat (8) begin
      tick;
      if (ov16) sp++;
    end
    chk("mid-reset no emission", sp, 0);
    run16(tbl[4], "post-reset op");

    // WIDTH=8, STAGES=1.
    a81 = 8'h7F; b81 = 8'h01; cin81 = 1'b0; sub81 = 1'b0; iv81 = 1'b1;
    #1;
    chk("8x1 in_ready", ir81, 1);
    tick;
    iv81 = 1'b0;
    e = 0;
    while (!ov81 && e < 20) begin
      tick;
      e++;
    end
    chk("8x1 latency", e, 1);
    chk("8x1 sum", s81, 8'h80);
    chk("8x1 cout", co81, 0);
    chk("8x1 ovf", of81, 1);

    // WIDTH=8, STAGES=8.
    a88 = 8'hFF; b88 = 8'h00; cin88 = 1'b1; sub88 = 1'b0; iv88 = 1'b1;
    #1;
    chk("8x8 in_ready", ir88, 1);
    tick;
    iv88 = 1'b0;
    e = 0;
    while (!ov88 && e < 20) begin
      tick;
      e++;
    end
    chk("8x8 latency", e, 8);
    chk("8x8 sum", s88, 8'h00);
    chk("8x8 cout", co88, 1);
    chk("8x8 ovf", of88, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_add.md
# pipe_add

Parametrised, pipelined WIDTH-bit adder/subtractor that generalises the team's single-bit full adder. The carry chain is split into STAGES equal chunks, with a register between chunks. It accepts one operation per cycle through a valid/ready handshake and adds subtract mode, carry-in/borrow-in and signed-overflow detection. It sits between operand producers and any arithmetic consumer that needs a registered, back-pressurable result.

## Interface
- WIDTH, 16, operand and result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages. CHUNK = WIDTH/STAGES bits are summed per stage; STAGES >= 1.
- sys_clk  input  1  single clock; all state updates on the rising edge.
- sys_rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept; transfer when in_valid && in_ready at a rising edge.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of MSB. When sub=1, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

## Operation
- Effective operands: b_eff = sub ? ~b : b; c0 = cin ^ sub.
  - sub=0: sum = a + b + cin.
  - sub=1: sum = a - b - cin.
- Stage k (0..STAGES-1) adds chunk k of a and b_eff plus the registered carry from stage k-1; stage 0 uses c0.
- Upper operand chunks are skew-delayed, and lower result chunks are de-skew-delayed, so that all chunks of one operation emerge together.
- Each stage holds a valid bit. Operations never reorder, merge or drop.
- Final stage outputs:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Flow control uses a global advance enable, en = !out_valid || out_ready.
  - All stage registers, including the valid bits, load only when en = 1.
  - in_ready = en && !sys_rst.
  - There is no bubble collapsing: a stall freezes the whole pipe even if interior stages are empty.
- While stalled (out_valid=1, out_ready=0), sum, cout and ovf are held stable.
- Reset (sys_rst=1 at an edge) clears:
  - all valid bits to 0;
  - all data registers, sum, cout and ovf to 0.
  - In-flight operations are discarded and never emitted.
- If reset and an input handshake coincide, reset wins and the operand is discarded.

## Timing
- Latency: an operation accepted at edge N appears with out_valid=1 after edge N+STAGES, provided no stall occurred. Each stall cycle adds one cycle.
- Throughput: one operation per cycle with out_ready held high.
- in_ready is combinational from out_valid, out_ready and sys_rst. There is no combinational path from a, b, cin or sub to any output.
- First cycle after sys_rst deasserts: out_valid=0, in_ready=1.
- A simultaneous output transfer and input acceptance in one cycle is legal and required at full rate.
- STAGES=1 degenerates to a single registered WIDTH-bit adder with latency 1.

## Test plan
- Reset: hold sys_rst for 2 cycles with random inputs -> out_valid=0, sum=0, cout=0, ovf=0. in_ready=0 during reset and 1 on the first cycle after.
- Full carry ripple (WIDTH=16, STAGES=4): a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0, out_valid exactly 4 cycles after acceptance.
- Subtract overflow: a=0x8000, b=0x0001, cin=0, sub=1 -> sum=0x7FFF, cout=1, ovf=1. Also a=0x0000, b=0x0001, sub=1 -> sum=0xFFFF, cout=0, ovf=0.
- Back-pressure: stream 8 random operations back-to-back and drop out_ready for 3 cycles mid-stream -> in_ready=0 and outputs frozen during the stall. All 8 results match a reference model, in order, with no loss or duplication.
- Reset mid-operation: 3 operations in flight, pulse sys_rst for 1 cycle -> out_valid=0 next cycle; none of the 3 results is ever emitted; a new operation then completes with latency STAGES.
- Parameter sweep: WIDTH=8, STAGES=1 with 0x7F + 0x01 -> sum=0x80, ovf=1, latency 1. WIDTH=8, STAGES=8 with 0xFF + 0x00, cin=1 -> sum=0x00, cout=1, latency 8.
